// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues one fetch at a time to instruction
// memory, waits a fixed latency, captures the word into a 2-entry buffer
// and presents the buffer head to decode. Redirects flush and re-steer.
module instr_fetch_ctrl #(
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MEM_BYTES = 40,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        addr_err
);

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  LAT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W:0]   MEM_LIMIT  = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        count_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [31:0]       buf_instr_q [2];
  logic [31:0]       buf_pc_q    [2];
  logic              addr_err_q;

  logic              issue;
  logic              capture;
  logic              pop;
  logic [ADDR_W:0]   pc_plus4;
  logic [ADDR_W-1:0] pc_seq_next;
  logic              redirect_oob;
  logic [ADDR_W-1:0] redirect_target;

  // Sequential successor of pc with wrap at the end of instruction memory
  always_comb begin
    pc_plus4    = {1'b0, pc_q} + (ADDR_W+1)'(4);
    pc_seq_next = (pc_plus4 >= MEM_LIMIT) ? RESET_ADDR : pc_plus4[ADDR_W-1:0];
  end

  // Redirect target: word-aligned, out-of-range targets fall back to reset pc
  always_comb begin
    redirect_oob    = ({1'b0, redirect_pc} >= MEM_LIMIT);
    redirect_target = redirect_oob ? RESET_ADDR : {redirect_pc[31:2], 2'b00};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and issue/capture decode; redirect overrides everything
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!halt && (count_q < 2'd2)) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      issue   = 1'b0;
      capture = 1'b0;
      state_d = IDLE;
    end
  end

  assign fetch_valid = (count_q != 2'd0);
  assign pop         = fetch_valid && fetch_ready && !redirect_valid;

  // PC, latency counter and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_ADDR;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_target;
      cnt_q      <= '0;
      addr_err_q <= redirect_oob;
    end else begin
      addr_err_q <= 1'b0;
      if (issue) begin
        cnt_q <= LAT_LOAD;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) begin
        pc_q <= pc_seq_next;
      end
    end
  end

  // Two-entry fetch buffer; a redirect flushes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else if (redirect_valid) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (capture) begin
        buf_instr_q[wr_ptr_q] <= imem_instr;
        buf_pc_q[wr_ptr_q]    <= pc_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({capture, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign fetch_instr = buf_instr_q[rd_ptr_q];
  assign fetch_pc    = buf_pc_q[rd_ptr_q];
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl (MEM_LAT=2, MEM_BYTES=40, RESET_PC=0).
// Memory returns 32'h5800_0000 + address. Inputs change and outputs are
// sampled 1 time unit after each rising edge; "E<n>" is the n-th edge after
// the stimulus point named in each scenario.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        addr_err;

  int n_checks;
  int n_errors;

  instr_fetch_ctrl #(
    .MEM_LAT  (2),
    .MEM_BYTES(40),
    .RESET_PC (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt          (halt),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_instr   (fetch_instr),
    .fetch_pc      (fetch_pc),
    .addr_err      (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = 32'h5800_0000 + imem_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves rst_n=1 just after an edge; the following cycle is the first issue cycle
  task automatic do_reset(input logic rdy);
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = rdy;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset values
    do_reset(1'b1);
    check_eq("rst_valid", 32'(fetch_valid), 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);
    check_eq("rst_err", 32'(addr_err), 32'd0);
    check_eq("rst_instr", fetch_instr, 32'd0);
    check_eq("rst_pc", fetch_pc, 32'd0);

    // Basic stream, ready=1: capture at E3, addresses step every 3 cycles
    step(2);
    check_eq("s1_valid_e2", 32'(fetch_valid), 32'd0);
    step(1);
    check_eq("s1_valid_e3", 32'(fetch_valid), 32'd1);
    check_eq("s1_pc_e3", fetch_pc, 32'd0);
    check_eq("s1_instr_e3", fetch_instr, 32'h5800_0000);
    check_eq("s1_addr_e3", imem_addr, 32'd4);
    step(1);
    check_eq("s1_valid_e4", 32'(fetch_valid), 32'd0);
    step(2);
    check_eq("s1_addr_e6", imem_addr, 32'd8);
    check_eq("s1_pc_e6", fetch_pc, 32'd4);
    step(3);
    check_eq("s1_addr_e9", imem_addr, 32'd12);
    step(3);
    check_eq("s1_addr_e12", imem_addr, 32'd16);

    // Back-pressure: two entries, issue stops at 8, pops in order
    do_reset(1'b0);
    step(10);
    check_eq("s2_valid", 32'(fetch_valid), 32'd1);
    check_eq("s2_head_pc", fetch_pc, 32'd0);
    check_eq("s2_head_instr", fetch_instr, 32'h5800_0000);
    check_eq("s2_addr_hold", imem_addr, 32'd8);
    fetch_ready = 1'b1;
    step(1);
    check_eq("s2_pop1_pc", fetch_pc, 32'd4);
    check_eq("s2_pop1_instr", fetch_instr, 32'h5800_0004);
    step(1);
    check_eq("s2_pop2_valid", 32'(fetch_valid), 32'd0);

    // Redirect to 14 while waiting on pc 4
    do_reset(1'b0);
    step(4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd14;
    step(1);
    redirect_valid = 1'b0;
    check_eq("s3_flush", 32'(fetch_valid), 32'd0);
    check_eq("s3_addr", imem_addr, 32'd12);
    check_eq("s3_err", 32'(addr_err), 32'd0);
    step(1);
    check_eq("s3_no_push", 32'(fetch_valid), 32'd0);
    step(2);
    check_eq("s3_valid", 32'(fetch_valid), 32'd1);
    check_eq("s3_pc", fetch_pc, 32'd12);
    check_eq("s3_instr", fetch_instr, 32'h5800_000C);

    // Out-of-range redirect to 44
    do_reset(1'b0);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd44;
    step(1);
    redirect_valid = 1'b0;
    check_eq("s4_err_hi", 32'(addr_err), 32'd1);
    check_eq("s4_addr", imem_addr, 32'd0);
    step(1);
    check_eq("s4_err_lo", 32'(addr_err), 32'd0);
    step(2);
    check_eq("s4_pc", fetch_pc, 32'd0);
    check_eq("s4_valid", 32'(fetch_valid), 32'd1);

    // Sequential wrap from 36
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd36;
    step(1);
    redirect_valid = 1'b0;
    check_eq("s5_addr36", imem_addr, 32'd36);
    step(3);
    check_eq("s5_wrap_addr", imem_addr, 32'd0);
    check_eq("s5_pc36", fetch_pc, 32'd36);
    check_eq("s5_instr36", fetch_instr, 32'h5800_0024);

    // Reset during WAIT with one entry buffered
    do_reset(1'b0);
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_eq("s6_valid", 32'(fetch_valid), 32'd0);
    check_eq("s6_addr", imem_addr, 32'd0);
    step(2);
    check_eq("s6_valid_e2", 32'(fetch_valid), 32'd0);
    step(1);
    check_eq("s6_refetch", 32'(fetch_valid), 32'd1);
    check_eq("s6_refetch_pc", fetch_pc, 32'd0);

    // Simultaneous push and pop at count 1
    do_reset(1'b0);
    step(5);
    fetch_ready = 1'b1;
    step(1);
    fetch_ready = 1'b0;
    check_eq("s7_valid", 32'(fetch_valid), 32'd1);
    check_eq("s7_head", fetch_pc, 32'd4);
    step(1);
    fetch_ready = 1'b1;
    step(1);
    fetch_ready = 1'b0;
    check_eq("s7_count1", 32'(fetch_valid), 32'd0);

    // Halt in WAIT completes the fetch but blocks the next issue
    do_reset(1'b0);
    step(1);
    halt = 1'b1;
    step(2);
    check_eq("s8_valid", 32'(fetch_valid), 32'd1);
    check_eq("s8_addr", imem_addr, 32'd4);
    step(4);
    check_eq("s8_hold_addr", imem_addr, 32'd4);
    check_eq("s8_hold_pc", fetch_pc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
